// File: rtl/layer_sequencer.sv
// Mode-word decoder driving serial buffer loads and PE compute passes.
// Optional sticky err output when LAYER_SEQ_ERR_EN is defined.
module layer_sequencer #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int ROWS     = 32,
  parameter int PIPE_LAT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [31:0]              mode,
  input  logic [31:0]              in_data,
  output logic                     wr_en,
  output logic                     wr_sel,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [$clog2(ROWS)-1:0]  rd_addr,
  output logic                     pe_valid,
  output logic                     pe_clear,
  output logic                     pe_dir,
  output logic                     acc_flush,
  output logic                     busy,
  output logic                     done
`ifdef LAYER_SEQ_ERR_EN
  ,
  output logic                     err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(ROWS);
  localparam int BW = $clog2(DATA_W);
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT);
  localparam logic [DW-1:0] D_FLSH = DW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t state;
  logic [3:0] op;
  logic [3:0] passes;
  logic [3:0] pass;
  logic op_nop;
  logic op_load;
  logic run_go;
  logic run_nil;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] word_nxt;
  logic [BW-1:0] bits;
  logic [AW-1:0] ptr_w;
  logic [AW-1:0] ptr_a;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_nxt;
  logic [RW-1:0] row;
  logic [DW-1:0] drain;
  logic unused;

  assign op       = mode[3:0];
  assign op_nop   = op == 4'd0;
  assign op_load  = op == 4'd2;
  assign run_go   = op == 4'd1 && mode[15:12] != 4'd0;
  assign run_nil  = op == 4'd1 && mode[15:12] == 4'd0;
  assign ptr      = wr_sel ? ptr_w : ptr_a;
  assign ptr_nxt  = (ptr == A_LAST) ? '0 : ptr + 1'b1;
  assign word_nxt = {in_data[0], word[DATA_W-1:1]};
  assign unused   = ^{mode[31:16], mode[11:8],
                      mode[6:5], in_data[31:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wr_en     <= 1'b0;
      wr_sel    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr   <= '0;
      pe_valid  <= 1'b0;
      pe_clear  <= 1'b0;
      pe_dir    <= 1'b0;
      acc_flush <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      word      <= '0;
      bits      <= '0;
      ptr_w     <= '0;
      ptr_a     <= '0;
      passes    <= '0;
      pass      <= '0;
      row       <= '0;
      drain     <= '0;
    end else begin
      wr_en     <= 1'b0;
      pe_valid  <= 1'b0;
      pe_clear  <= 1'b0;
      acc_flush <= 1'b0;
      done      <= 1'b0;
      if (enable) begin
        unique case (state)
          S_IDLE: begin
            unique case (1'b1)
              op_load: begin
                state  <= S_LOAD;
                busy   <= 1'b1;
                wr_sel <= mode[7];
                word   <= '0;
                bits   <= '0;
                if (mode[7]) ptr_w <= '0;
                else         ptr_a <= '0;
              end
              run_go: begin
                state  <= S_RUN;
                busy   <= 1'b1;
                pe_dir <= mode[4];
                passes <= mode[15:12];
                pass   <= '0;
                row    <= '0;
              end
              run_nil: begin
                state <= S_DONE;
                done  <= 1'b1;
              end
              default: ;
            endcase
          end
          S_LOAD: begin
            if (op_load) begin
              word <= word_nxt;
              if (bits == B_LAST) begin
                wr_en   <= 1'b1;
                wr_data <= word_nxt;
                wr_addr <= ptr;
                bits    <= '0;
                if (wr_sel) ptr_w <= ptr_nxt;
                else        ptr_a <= ptr_nxt;
              end else begin
                bits <= bits + 1'b1;
              end
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
              word  <= '0;
              bits  <= '0;
            end
          end
          S_RUN: begin
            pe_valid <= 1'b1;
            pe_clear <= row == '0;
            rd_addr  <= row;
            if (row == R_LAST) begin
              row <= '0;
              if (pass == passes - 4'd1) begin
                state <= S_DRAIN;
                drain <= '0;
              end else begin
                pass <= pass + 4'd1;
              end
            end else begin
              row <= row + 1'b1;
            end
          end
          S_DRAIN: begin
            // last count is the done-entry cycle, one past the flush
            if (drain == D_LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              acc_flush <= drain == D_FLSH;
              drain     <= drain + 1'b1;
            end
          end
          S_DONE: begin
            if (op_nop) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef LAYER_SEQ_ERR_EN
  logic illegal;
  assign illegal = op > 4'd2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else if (enable && state == S_IDLE
             && (illegal || run_nil)) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: behavioural load/run model,
// queued expectations, negedge monitor.
module tb_layer_sequencer;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 256;
  localparam int ROWS     = 32;
  localparam int PIPE_LAT = 3;
  localparam int AW       = $clog2(DEPTH);
  localparam int RW       = $clog2(ROWS);

  logic clk = 0;
  logic rst_n = 1;
  logic enable = 0;
  logic [31:0] mode = 0;
  logic [31:0] in_data = 0;
  logic wr_en, wr_sel, pe_valid, pe_clear, pe_dir;
  logic acc_flush, busy, done;
  logic [AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [RW-1:0] rd_addr;
`ifdef LAYER_SEQ_ERR_EN
  logic err;
`endif

  layer_sequencer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH),
    .ROWS(ROWS), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .reset(rst_n), .enable(enable),
    .mode(mode), .in_data(in_data),
    .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .pe_valid(pe_valid),
    .pe_clear(pe_clear), .pe_dir(pe_dir),
    .acc_flush(acc_flush), .busy(busy), .done(done)
`ifdef LAYER_SEQ_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sel;
    int   addr;
    int   data;
  } wr_t;

  typedef struct {
    int   when;
    int   nvalid;
    int   nclear;
    int   nflush;
    logic dir;
  } run_t;

  wr_t wq[$];
  run_t rq[$];
  bit bitq[$];
  int checks = 0;
  int failures = 0;
  int ecyc = 0;
  int vcnt = 0;
  int ccnt = 0;
  int fcnt = 0;
  int mptr[2];

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  // count of enabled clock edges since time zero
  always @(posedge clk) if (rst_n && enable) ecyc <= ecyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      vcnt = 0;
      ccnt = 0;
      fcnt = 0;
    end else begin
      if (wr_en) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_sel", wr_sel, w.sel);
          chk("wr_addr", wr_addr, w.addr);
          chk("wr_data", wr_data, w.data);
        end
      end
      if (pe_valid) begin
        if (rq.size() == 0) chk("unexpected_pe_valid", 1, 0);
        else begin
          chk("rd_addr", rd_addr, vcnt % ROWS);
          chk("pe_clear", pe_clear, (vcnt % ROWS) == 0);
          chk("pe_dir", pe_dir, rq[0].dir);
          chk("busy_run", busy, 1);
        end
        vcnt++;
        if (pe_clear) ccnt++;
      end else if (pe_clear) begin
        chk("stray_pe_clear", 1, 0);
      end
      if (acc_flush) begin
        fcnt++;
        if (pe_valid) chk("flush_with_valid", 1, 0);
      end
      if (done) begin
        if (rq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          run_t r;
          r = rq.pop_front();
          chk("done_cycle", ecyc, r.when);
          chk("valid_count", vcnt, r.nvalid);
          chk("clear_count", ccnt, r.nclear);
          chk("flush_count", fcnt, r.nflush);
          chk("busy_done", busy, 0);
        end
        vcnt = 0;
        ccnt = 0;
        fcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_nop();
    logic [31:0] r;
    r = $urandom();
    r[3:0] = 4'd0;
    mode = r;
    enable = 1;
    tick();
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_sel"}, wr_sel, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_pe_valid"}, pe_valid, 0);
    chk({tag, "_pe_clear"}, pe_clear, 0);
    chk({tag, "_pe_dir"}, pe_dir, 0);
    chk({tag, "_acc_flush"}, acc_flush, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef LAYER_SEQ_ERR_EN
    chk({tag, "_err"}, err, 0);
`endif
  endtask

  task automatic run_cmd(input logic [31:0] base, input int p,
                         input bit dir, input int stall_at,
                         input int stall_len, input bit rstall,
                         input int hold);
    logic [31:0] w;
    logic [31:0] r;
    int n;
    w = base;
    w[3:0] = 4'd1;
    w[4] = dir;
    w[15:12] = 4'(p);
    mode = w;
    enable = 1;
    rq.push_back('{(p == 0) ? ecyc + 1
                            : ecyc + 1 + p * ROWS + PIPE_LAT + 1,
                   p * ROWS, p, (p == 0) ? 0 : 1, dir});
    tick();
    n = 0;
    while (!done && n < 3000) begin
      if (rstall) begin
        enable = $urandom_range(0, 3) != 0;
        r = $urandom();
        mode = r;
      end else begin
        enable = !(n >= stall_at && n < stall_at + stall_len);
      end
      tick();
      n++;
    end
    if (!done) chk("run_timeout", n, -1);
    mode = w;
    for (int i = 0; i < hold; i++) begin
      enable = $urandom_range(0, 3) != 0;
      tick();
    end
    idle_nop();
  endtask

  task automatic load_cmd(input bit sel, input bit rmode);
    logic [31:0] r;
    bit b;
    bit en;
    int nb;
    int w;
    r = $urandom();
    r[3:0] = 4'd2;
    r[7] = sel;
    mode = r;
    enable = 1;
    tick();
    mptr[sel] = 0;
    nb = 0;
    w = 0;
    while (bitq.size() > 0) begin
      b = bitq.pop_front();
      r = $urandom();
      r[0] = b;
      in_data = r;
      if (rmode) begin
        r = $urandom();
        r[3:0] = 4'd2;
        mode = r;
      end
      do begin
        en = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
        enable = en;
        tick();
      end while (!en);
      w = w | (int'(b) << nb);
      nb++;
      if (nb == DATA_W) begin
        wq.push_back('{sel, mptr[sel], w});
        mptr[sel] = (mptr[sel] + 1) % DEPTH;
        nb = 0;
        w = 0;
      end
    end
    idle_nop();
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [31:0] r;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    outs_zero("reset");
    rst_n = 1;
    tick();

    bitq = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    load_cmd(1'b1, 1'b0);

    bitq = '{1, 1, 0, 1, 1};
    load_cmd(1'b0, 1'b0);
    bitq = '{0, 1, 1, 0, 0, 1, 0, 1};
    load_cmd(1'b0, 1'b0);

    run_cmd(32'h0000_1801, 1, 1'b0, 0, 0, 1'b0, 3);
    run_cmd(32'h0000_2811, 2, 1'b1, 10, 5, 1'b0, 2);

    mode = 32'h0000_3001;
    enable = 1;
    rq.push_back('{0, 0, 0, 0, 1'b0});
    tick();
    repeat (20) tick();
    rst_n = 0;
    #1;
    outs_zero("midrun");
    rq.delete();
    mode = 0;
    repeat (3) tick();
    rst_n = 1;
    repeat (120) tick();
    chk("post_reset_busy", busy, 0);

    for (int i = 0; i < (DEPTH + 1) * DATA_W; i++)
      bitq.push_back(1'($urandom_range(0, 1)));
    load_cmd(1'($urandom_range(0, 1)), 1'b0);

`ifdef LAYER_SEQ_ERR_EN
    chk("err_before", err, 0);
    mode = 32'h0000_0005;
    enable = 1;
    tick();
    chk("err_set", err, 1);
    idle_nop();
    repeat (4) tick();
    chk("err_sticky", err, 1);
`endif

    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          r = $urandom();
          run_cmd(r, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                  0, 0, 1'b1, $urandom_range(0, 4));
        end
        1: begin
          for (int i = $urandom_range(0, 40); i > 0; i--)
            bitq.push_back(1'($urandom_range(0, 1)));
          load_cmd(1'($urandom_range(0, 1)), 1'b1);
        end
        default: begin
          r = $urandom();
          r[3:0] = 4'($urandom_range(3, 15));
          mode = r;
          enable = 1;
          repeat (3) tick();
          idle_nop();
        end
      endcase
    end

    repeat (5) tick();
    chk("writes_drained", wq.size(), 0);
    chk("runs_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
